// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad port block: button bit positions,
// shift register length and the Four Score signature bytes.
package nes_joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int SR_LEN = 24;

  localparam logic [7:0] FOURSCORE_SIG [0:3] = '{8'h08, 8'h04, 8'h00, 8'h00};

endpackage

// File: rtl/nes_joypad_shifter.sv
// One controller port: falling-edge detect on the port read clock, parallel
// load while strobe is high, serial shift toward bit 0 otherwise.
module nes_joypad_shifter
  import nes_joypad_pkg::*;
#(
  parameter logic FILL_BIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              strobe,
  input  logic              port_clk,
  input  logic [SR_LEN-1:0] load_val,
  output logic              data
);

  logic              port_clk_q;
  logic              fall;
  logic [SR_LEN-1:0] sr;

  assign fall = port_clk_q & ~port_clk;

  // Load has priority over a coincident falling edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      port_clk_q <= 1'b0;
      sr         <= '0;
    end else begin
      port_clk_q <= port_clk;
      if (strobe) begin
        sr <= load_val;
      end else if (fall) begin
        sr <= {FILL_BIT, sr[SR_LEN-1:1]};
      end
    end
  end

  assign data = sr[0];

endmodule

// File: rtl/nes_joypad_ports.sv
// NES controller ports with turbo masking and optional Four Score
// multiplexing (enabled by defining NES_JOYPAD_FOURSCORE_EN).
module nes_joypad_ports
  import nes_joypad_pkg::*;
#(
  parameter int   NUM_PORTS = 2,
  parameter logic FILL_BIT  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     strobe,
  input  logic [NUM_PORTS-1:0]     port_clk,
  input  logic [2*NUM_PORTS*8-1:0] pad_in,
  input  logic                     fourscore_en,
  input  logic [2*NUM_PORTS*2-1:0] turbo_mask,
  input  logic                     turbo_tick,
  output logic [NUM_PORTS-1:0]     port_data
);

  localparam int NUM_PADS = 2 * NUM_PORTS;

  logic                     turbo_phase;
  logic [NUM_PADS*8-1:0]    pad_eff;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      turbo_phase <= 1'b1;
    end else if (turbo_tick) begin
      turbo_phase <= ~turbo_phase;
    end
  end

  // Turbo-enabled A/B buttons read as released during the low phase.
  always_comb begin
    pad_eff = pad_in;
    if (!turbo_phase) begin
      for (int k = 0; k < NUM_PADS; k++) begin
        if (turbo_mask[2*k])   pad_eff[8*k+BTN_A] = 1'b0;
        if (turbo_mask[2*k+1]) pad_eff[8*k+BTN_B] = 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [SR_LEN-1:0] load_val;

`ifdef NES_JOYPAD_FOURSCORE_EN
    assign load_val = fourscore_en
      ? {FOURSCORE_SIG[p], pad_eff[8*(p+NUM_PORTS) +: 8], pad_eff[8*p +: 8]}
      : {{(SR_LEN-8){FILL_BIT}}, pad_eff[8*p +: 8]};
`else
    assign load_val = {{(SR_LEN-8){FILL_BIT}}, pad_eff[8*p +: 8]};
`endif

    nes_joypad_shifter #(
      .FILL_BIT (FILL_BIT)
    ) u_shifter (
      .clk      (clk),
      .reset_n  (reset_n),
      .strobe   (strobe),
      .port_clk (port_clk[p]),
      .load_val (load_val),
      .data     (port_data[p])
    );
  end

`ifndef NES_JOYPAD_FOURSCORE_EN
  // Second-bank pads and the mode select only matter for Four Score builds.
  logic unused_fourscore;
  assign unused_fourscore = ^{fourscore_en, pad_eff[NUM_PADS*8-1:NUM_PORTS*8]};
`endif

endmodule

// File: tb/tb_nes_joypad_ports.sv
// Bench for nes_joypad_ports: queue-based reference model of each port's
// bit stream, scoreboard of expected port_data, directed plus random stimulus.
module tb_nes_joypad_ports;

  localparam int   N    = 4;
  localparam logic FILL = 1'b1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             strobe;
  logic [N-1:0]     port_clk;
  logic [2*N*8-1:0] pad_in;
  logic             fourscore_en;
  logic [2*N*2-1:0] turbo_mask;
  logic             turbo_tick;
  logic [N-1:0]     port_data;

  nes_joypad_ports #(
    .NUM_PORTS (N),
    .FILL_BIT  (FILL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .strobe       (strobe),
    .port_clk     (port_clk),
    .pad_in       (pad_in),
    .fourscore_en (fourscore_en),
    .turbo_mask   (turbo_mask),
    .turbo_tick   (turbo_tick),
    .port_data    (port_data)
  );

  initial forever #5 clk = ~clk;

  // Reference model: each port is the list of bits still to be read out.
  bit           mq [N][$];
  bit           mprev [N];
  bit           mphase;
  logic [7:0]   sig_tbl [4] = '{8'h08, 8'h04, 8'h00, 8'h00};
  logic [N-1:0] sb [$];
  int           tests = 0;
  int           fails = 0;

  function automatic logic [7:0] pad_val(int k);
    logic [7:0] v;
    v = pad_in[8*k +: 8];
    if (!mphase) begin
      if (turbo_mask[2*k])   v[0] = 1'b0;
      if (turbo_mask[2*k+1]) v[1] = 1'b0;
    end
    return v;
  endfunction

  task automatic load_port(int p);
    logic [7:0] a;
    a = pad_val(p);
    mq[p].delete();
    for (int i = 0; i < 8; i++) mq[p].push_back(a[i]);
`ifdef NES_JOYPAD_FOURSCORE_EN
    if (fourscore_en) begin
      logic [7:0] b;
      logic [7:0] s;
      b = pad_val(p + N);
      s = sig_tbl[p];
      for (int i = 0; i < 8; i++) mq[p].push_back(b[i]);
      for (int i = 0; i < 8; i++) mq[p].push_back(s[i]);
    end
`endif
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      for (int p = 0; p < N; p++) begin
        mq[p].delete();
        for (int i = 0; i < 24; i++) mq[p].push_back(1'b0);
        mprev[p] = 1'b0;
      end
      mphase = 1'b1;
    end else begin
      for (int p = 0; p < N; p++) begin
        bit fall;
        fall = mprev[p] && !port_clk[p];
        if (strobe) load_port(p);
        else if (fall && mq[p].size() > 0) void'(mq[p].pop_front());
        mprev[p] = port_clk[p];
      end
      if (turbo_tick) mphase = !mphase;
    end
  endtask

  function automatic logic [N-1:0] model_out();
    logic [N-1:0] o;
    for (int p = 0; p < N; p++) o[p] = (mq[p].size() > 0) ? mq[p][0] : FILL;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    sb.push_back(model_out());
  endtask

  task automatic fall_port(int p);
    port_clk[p] = 1'b1;
    step();
    port_clk[p] = 1'b0;
    step();
  endtask

  task automatic latch();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
  endtask

  // Monitor: compares every registered output against the model's prediction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [N-1:0] e;
      e = sb.pop_front();
      tests++;
      if (port_data !== e) begin
        fails++;
        $display("FAIL sb_port_data t=%0t actual=%b required=%b", $time, port_data, e);
      end
    end
  end

  logic [9:0] basic_exp;

  initial begin
    reset_n = 1'b0; strobe = 1'b0; port_clk = '0; pad_in = '0;
    fourscore_en = 1'b0; turbo_mask = '0; turbo_tick = 1'b0;
    mphase = 1'b1;
    for (int p = 0; p < N; p++) mprev[p] = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Basic read of pad0 = 0x81: A, six zeros, Right, then fill.
    basic_exp = 10'b11_1000_0001;
    pad_in[7:0] = 8'h81;
    latch();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (port_data[0] !== basic_exp[i]) begin
        fails++;
        $display("FAIL basic_read idx=%0d actual=%b required=%b", i, port_data[0], basic_exp[i]);
      end
      fall_port(0);
    end

    // Four Score read on port 0 (second pad is pad N).
    fourscore_en = 1'b1;
    pad_in = '0;
    pad_in[7:0] = 8'h01;
    pad_in[8*N +: 8] = 8'h02;
    latch();
    for (int i = 0; i < 26; i++) fall_port(0);
    fourscore_en = 1'b0;

    // Strobe held: output tracks A with no shifting.
    strobe = 1'b1;
    pad_in[7:0] = 8'h00;
    step();
    port_clk = '1; step(); port_clk = '0; step();
    pad_in[7:0] = 8'h01;
    step();
    port_clk = '1; step(); port_clk = '0; step();
    strobe = 1'b0;
    step();

    // Turbo on pad0 A.
    turbo_mask = '0;
    turbo_mask[0] = 1'b1;
    pad_in[7:0] = 8'h01;
    turbo_tick = 1'b1; step(); turbo_tick = 1'b0;
    latch();
    fall_port(0);
    turbo_tick = 1'b1; step(); turbo_tick = 1'b0;
    latch();
    turbo_mask = '0;

    // Reset in the middle of a read of 0xFF.
    pad_in[7:0] = 8'hFF;
    latch();
    for (int i = 0; i < 3; i++) fall_port(0);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) fall_port(0);

    // All ports fall together while strobe rises on that same cycle.
    pad_in = {$urandom, $urandom};
    latch();
    port_clk = '1; step();
    port_clk = '0; strobe = 1'b1; pad_in = {$urandom, $urandom}; step();
    strobe = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      port_clk = '1; step(); port_clk = '0; step();
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      strobe     = ($urandom_range(0, 11) == 0);
      port_clk   = N'($urandom);
      turbo_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) pad_in = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) turbo_mask = 16'($urandom);
      if ($urandom_range(0, 39) == 0) fourscore_en = ~fourscore_en;
      step();
    end
    reset_n = 1'b1; strobe = 1'b0; turbo_tick = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL sb_drain remaining=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
